// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- stall/flush sequencer for the 5-stage MIPS pipeline.
//
// Drives the enable and clear controls of the F/D, D/E, E/M and M/W pipeline
// registers. It resolves load-use and HI/LO hazards, tracks how long the
// multi-cycle mult/div unit is busy, sequences interrupt entry and eret
// return, and counts stall cycles.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ld_use_hazD         instr in D needs a load result that is still in E
//   md_useD             instr in D touches HI/LO or is itself mult/div
//   md_startE/md_is_divE  mult/div issuing in EX (1=div, 0=mult)
//   Int                 level interrupt request from CP0
//   eretD               eret decoded in D
//   stallF/stallD       hold PC / hold F/D register
//   flushD/E/M          clear F/D, D/E, E/M registers
//   pc_sel_exc/epc      PC <- exception vector / PC <- EPC
//   int_ack             one-cycle interrupt accept pulse to CP0
//   md_busy             HI/LO result still pending
//   in_isr              handler active, interrupts masked
//   stall_cycles        saturating stall-cycle count
module pipe_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_use_hazD,
  input  logic        md_useD,
  input  logic        md_startE,
  input  logic        md_is_divE,
  input  logic        Int,
  input  logic        eretD,
  output logic        stallF,
  output logic        stallD,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic        pc_sel_exc,
  output logic        pc_sel_epc,
  output logic        int_ack,
  output logic        md_busy,
  output logic        in_isr,
  output logic [31:0] stall_cycles
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             in_isr_q, in_isr_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic raw_stall, int_acc, eret_acc, stall_cyc, md_acc;

  assign md_busy      = (md_cnt_q != '0);
  assign in_isr       = in_isr_q;
  assign stall_cycles = stall_cnt_q;

  // Hazard and acceptance decode. Every term is gated by reset so that all
  // controls read 0 while reset is held, whatever the inputs do.
  always_comb begin
    raw_stall = ld_use_hazD | (md_useD & (md_busy | md_startE));
    int_acc   = Int & ~in_isr_q & ~reset;
    stall_cyc = raw_stall & ~int_acc & ~reset;
    // eret waits out any stall so it never redirects PC from a held F/D.
    eret_acc  = eretD & ~int_acc & ~raw_stall & ~reset;
    // An interrupt discards the EX instruction, so its mult/div never issues.
    md_acc    = md_startE & ~int_acc & ~reset;
  end

  // Pipeline controls: interrupt > eret > stall.
  always_comb begin
    stallF     = 1'b0;
    stallD     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    flushM     = 1'b0;
    pc_sel_exc = 1'b0;
    pc_sel_epc = 1'b0;
    int_ack    = 1'b0;
    if (int_acc) begin
      int_ack    = 1'b1;
      pc_sel_exc = 1'b1;
      flushD     = 1'b1;
      flushE     = 1'b1;
      flushM     = 1'b1;
    end else if (eret_acc) begin
      pc_sel_epc = 1'b1;
      flushD     = 1'b1;
    end else if (stall_cyc) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    md_cnt_d    = md_cnt_q;
    in_isr_d    = in_isr_q;
    stall_cnt_d = stall_cnt_q;

    // A start while busy just reloads; the stall normally prevents it.
    if (md_acc)
      md_cnt_d = md_is_divE ? DIV_CNT : MULT_CNT;
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - 1'b1;

    if (int_acc)
      in_isr_d = 1'b1;
    else if (eret_acc)
      in_isr_d = 1'b0;

    if (stall_cyc && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q    <= '0;
      in_isr_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      in_isr_q    <= in_isr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic reset, ld_use_hazD, md_useD, md_startE, md_is_divE, Int, eretD;
  logic stallF, stallD, flushD, flushE, flushM, pc_sel_exc, pc_sel_epc, int_ack;
  logic md_busy, in_isr;
  logic [31:0] stall_cycles;
  int total = 0;
  int bad = 0;

  // {stallF, stallD, flushD, flushE, flushM, pc_sel_exc, pc_sel_epc, int_ack}
  logic [7:0] ctl;
  assign ctl = {stallF, stallD, flushD, flushE, flushM, pc_sel_exc, pc_sel_epc, int_ack};
  localparam logic [7:0] C_NONE  = 8'h00;
  localparam logic [7:0] C_STALL = 8'b1101_0000;
  localparam logic [7:0] C_INT   = 8'b0011_1101;
  localparam logic [7:0] C_ERET  = 8'b0010_0010;

  pipe_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .ld_use_hazD(ld_use_hazD), .md_useD(md_useD),
    .md_startE(md_startE), .md_is_divE(md_is_divE), .Int(Int), .eretD(eretD),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .flushM(flushM), .pc_sel_exc(pc_sel_exc), .pc_sel_epc(pc_sel_epc),
    .int_ack(int_ack), .md_busy(md_busy), .in_isr(in_isr),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; checks happen 1ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    ld_use_hazD = 0; md_useD = 0; md_startE = 0; md_is_divE = 0; Int = 0; eretD = 0;
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    clr_in();
    reset = 1; ld_use_hazD = 1; Int = 1; eretD = 1; md_useD = 1; md_startE = 1;
    tick(); #1;
    total++; if (ctl !== C_NONE) begin bad++; $display("FAIL reset_ctl_during got=%b exp=%b", ctl, C_NONE); end
    tick();
    reset = 0; clr_in(); #1;
    total++; if (ctl !== C_NONE) begin bad++; $display("FAIL reset_ctl_after got=%b exp=%b", ctl, C_NONE); end
    total++; if ({md_busy, in_isr} !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", {md_busy, in_isr}); end
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles); end
  endtask

  task automatic test_ld_use();
    do_reset();
    ld_use_hazD = 1; #1;
    total++; if (ctl !== C_STALL) begin bad++; $display("FAIL lduse_stall got=%b exp=%b", ctl, C_STALL); end
    tick();
    ld_use_hazD = 0; #1;
    total++; if (ctl !== C_NONE) begin bad++; $display("FAIL lduse_release got=%b exp=%b", ctl, C_NONE); end
    total++; if (stall_cycles !== 32'd1) begin bad++; $display("FAIL lduse_cnt got=%0d exp=1", stall_cycles); end
  endtask

  task automatic test_mult_busy();
    do_reset();
    md_startE = 1; md_is_divE = 0; md_useD = 1; #1;
    total++; if (ctl !== C_STALL) begin bad++; $display("FAIL mult_t0_ctl got=%b exp=%b", ctl, C_STALL); end
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL mult_t0_busy got=%b exp=0", md_busy); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      md_startE = 0; #1;
      total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL mult_busy_t%0d got=%b exp=1", k, md_busy); end
      total++; if (ctl !== C_STALL) begin bad++; $display("FAIL mult_stall_t%0d got=%b exp=%b", k, ctl, C_STALL); end
    end
    tick(); #1;
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL mult_t6_busy got=%b exp=0", md_busy); end
    total++; if (ctl !== C_NONE) begin bad++; $display("FAIL mult_t6_ctl got=%b exp=%b", ctl, C_NONE); end
    md_useD = 0;
    tick(); #1;
    total++; if (stall_cycles !== 32'd6) begin bad++; $display("FAIL mult_cnt got=%0d exp=6", stall_cycles); end
  endtask

  // Div issued, interrupt mid-flight, then eret with Int still high.
  task automatic test_div_int_eret();
    do_reset();
    md_startE = 1; md_is_divE = 1; #1;
    total++; if (ctl !== C_NONE) begin bad++; $display("FAIL div_t0_ctl got=%b exp=%b", ctl, C_NONE); end
    tick(); md_startE = 0; md_is_divE = 0;
    tick();
    tick();
    Int = 1; #1;
    total++; if (ctl !== C_INT) begin bad++; $display("FAIL div_int_ctl got=%b exp=%b", ctl, C_INT); end
    total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL div_int_busy got=%b exp=1", md_busy); end
    tick(); #1;
    total++; if (in_isr !== 1'b1) begin bad++; $display("FAIL div_isr_set got=%b exp=1", in_isr); end
    total++; if (ctl !== C_NONE) begin bad++; $display("FAIL div_int_masked got=%b exp=%b", ctl, C_NONE); end
    for (int k = 5; k <= 10; k++) tick();
    #1;
    total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL div_t10_busy got=%b exp=1", md_busy); end
    tick(); #1;
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL div_t11_busy got=%b exp=0", md_busy); end
    eretD = 1; #1;
    total++; if (ctl !== C_ERET) begin bad++; $display("FAIL eret_ctl got=%b exp=%b", ctl, C_ERET); end
    tick();
    eretD = 0; #1;
    total++; if (in_isr !== 1'b0) begin bad++; $display("FAIL eret_isr_clr got=%b exp=0", in_isr); end
    total++; if (ctl !== C_INT) begin bad++; $display("FAIL eret_reint got=%b exp=%b", ctl, C_INT); end
    tick();
    Int = 0; #1;
    total++; if (in_isr !== 1'b1) begin bad++; $display("FAIL reint_isr got=%b exp=1", in_isr); end
  endtask

  task automatic test_int_vs_md();
    do_reset();
    Int = 1; md_startE = 1; md_is_divE = 1; md_useD = 1; #1;
    total++; if (ctl !== C_INT) begin bad++; $display("FAIL intmd_ctl got=%b exp=%b", ctl, C_INT); end
    tick();
    clr_in(); #1;
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL intmd_busy got=%b exp=0", md_busy); end
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL intmd_cnt got=%0d exp=0", stall_cycles); end
  endtask

  task automatic test_eret_held();
    do_reset();
    Int = 1;
    tick();
    Int = 0; eretD = 1; ld_use_hazD = 1; #1;
    total++; if (ctl !== C_STALL) begin bad++; $display("FAIL eret_held_ctl got=%b exp=%b", ctl, C_STALL); end
    tick();
    ld_use_hazD = 0; #1;
    total++; if (in_isr !== 1'b1) begin bad++; $display("FAIL eret_held_isr got=%b exp=1", in_isr); end
    total++; if (ctl !== C_ERET) begin bad++; $display("FAIL eret_retry_ctl got=%b exp=%b", ctl, C_ERET); end
    tick();
    eretD = 0; #1;
    total++; if (in_isr !== 1'b0) begin bad++; $display("FAIL eret_retry_isr got=%b exp=0", in_isr); end
  endtask

  task automatic test_reset_mid_div();
    do_reset();
    Int = 1;
    tick();
    Int = 0; md_startE = 1; md_is_divE = 1; md_useD = 1;
    tick();
    clr_in();
    tick();
    tick();
    tick(); #1;
    total++; if ({md_busy, in_isr} !== 2'b11) begin bad++; $display("FAIL mid_pre_state got=%b exp=11", {md_busy, in_isr}); end
    total++; if (stall_cycles !== 32'd1) begin bad++; $display("FAIL mid_pre_cnt got=%0d exp=1", stall_cycles); end
    reset = 1; ld_use_hazD = 1; eretD = 1; #1;
    total++; if (ctl !== C_NONE) begin bad++; $display("FAIL mid_rst_ctl got=%b exp=%b", ctl, C_NONE); end
    tick();
    reset = 0; clr_in(); #1;
    total++; if ({md_busy, in_isr} !== 2'b00) begin bad++; $display("FAIL mid_post_state got=%b exp=00", {md_busy, in_isr}); end
    total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL mid_post_cnt got=%0d exp=0", stall_cycles); end
    total++; if (ctl !== C_NONE) begin bad++; $display("FAIL mid_post_ctl got=%b exp=%b", ctl, C_NONE); end
  endtask

  initial begin
    clr_in();
    reset = 1;
    test_reset();
    test_ld_use();
    test_mult_busy();
    test_div_int_eret();
    test_int_vs_md();
    test_eret_held();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
